stream_capture_replay: RTL and testbench

- Synthesizable capture/replay endpoint for the valid/ready stream protocol used between the stream sources, Network and the stream sinks.
- Acts as a receiver (AM side): accepts exactly SIZE beats and stores them in an internal buffer.
- Then acts as a transmitter (BM side): replays the beats in order.
- Used on-chip as a loopback endpoint for Network output, and as the hardware counterpart of the file-based stream sink/source pair.

---
 rtl/stream_capture_replay_pkg.sv | 17 +
 rtl/lfsr16_gate.sv | 21 ++
 rtl/stream_capture_replay.sv | 133 +++++++++++++
 tb/tb_stream_capture_replay.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/stream_capture_replay_pkg.sv
// Shared definitions for the capture/replay endpoint and its LFSR gate.
package stream_capture_replay_pkg;

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    REPLAY  = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Right-shifting Fibonacci form: bits 0,2,3,5 are taps 16,14,13,11.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lfsr16_gate.sv
// 16-bit Fibonacci LFSR; oBit is used as a pseudo-random handshake gate.
module lfsr16_gate
  import stream_capture_replay_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic iCLK,
  input  logic iRST,
  output logic oBit
);

  logic [15:0] lfsr;

  always_ff @(posedge iCLK) begin
    if (iRST) lfsr <= SEED;
    else      lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
  end

  assign oBit = lfsr[0];

endmodule

// File: rtl/stream_capture_replay.sv
// Capture SIZE beats on the AM side, then replay them in order on the BM side.
// Optional capture checksum: define STREAM_CAPTURE_REPLAY_CHECKSUM_EN.
module stream_capture_replay
  import stream_capture_replay_pkg::*;
#(
  parameter int          SIZE  = 10,
  parameter int          WIDTH = 8,
  parameter              BURST = "yes",
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic                       iCLK,
  input  logic                       iRST,
  input  logic                       iValid_AM,
  output logic                       oReady_AM,
  input  logic [WIDTH-1:0]           iData_AM,
  output logic                       oValid_BM,
  input  logic                       iReady_BM,
  output logic [WIDTH-1:0]           oData_BM,
  output logic [$clog2(SIZE+1)-1:0]  oCount,
  output logic                       oDone,
  output logic [WIDTH-1:0]           oChecksum
);

  localparam int             CW   = cnt_w(SIZE);
  localparam int             AW   = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0]  LAST = CW'(SIZE - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mem [SIZE];
  logic [CW-1:0]    wptr, rptr, wptr_d, rptr_d, rd_idx, count_d;
  logic             ready_d, valid_d, done_d, data_ld, wr_en;
  logic             lfsr_bit, g, accept, hs;

  lfsr16_gate #(.SEED(SEED)) u_gate (
    .iCLK (iCLK),
    .iRST (iRST),
    .oBit (lfsr_bit)
  );

  assign g      = (BURST == "yes") ? 1'b1 : lfsr_bit;
  assign accept = (state == CAPTURE) && iValid_AM && oReady_AM;
  assign hs     = (state == REPLAY) && oValid_BM && iReady_BM;

  always_ff @(posedge iCLK) begin
    if (iRST) state <= CAPTURE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      CAPTURE: if (accept && wptr == LAST) state_nxt = REPLAY;
      REPLAY:  if (hs && rptr == LAST)     state_nxt = DONE;
      default: state_nxt = DONE;
    endcase
  end

  always_comb begin
    ready_d = 1'b0;
    valid_d = oValid_BM;
    done_d  = oDone;
    data_ld = 1'b0;
    wr_en   = 1'b0;
    wptr_d  = wptr;
    rptr_d  = rptr;
    rd_idx  = rptr;
    count_d = oCount;
    unique case (state)
      CAPTURE: begin
        wr_en   = accept;
        // Drop ready one cycle early so it is never high once the buffer is full.
        ready_d = g && ((wptr < LAST) || !accept);
        if (accept) begin
          wptr_d  = wptr + CW'(1);
          rptr_d  = '0;
          count_d = (wptr == LAST) ? '0 : oCount + CW'(1);
        end
      end
      REPLAY: begin
        if (hs) begin
          rptr_d  = rptr + CW'(1);
          count_d = oCount + CW'(1);
          if (rptr == LAST) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            valid_d = g;
            data_ld = 1'b1;
            rd_idx  = rptr + CW'(1);
          end
        end else if (!oValid_BM) begin
          valid_d = g;
          data_ld = 1'b1;
        end
      end
      default: valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (wr_en) mem[wptr[AW-1:0]] <= iData_AM;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oReady_AM <= 1'b0;
      oValid_BM <= 1'b0;
      oData_BM  <= '0;
      oCount    <= '0;
      oDone     <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
    end else begin
      oReady_AM <= ready_d;
      oValid_BM <= valid_d;
      oCount    <= count_d;
      oDone     <= done_d;
      wptr      <= wptr_d;
      rptr      <= rptr_d;
      if (data_ld) oData_BM <= mem[rd_idx[AW-1:0]];
    end
  end

`ifdef STREAM_CAPTURE_REPLAY_CHECKSUM_EN
  always_ff @(posedge iCLK) begin
    if (iRST)        oChecksum <= '0;
    else if (accept) oChecksum <= oChecksum + iData_AM;
  end
`else
  assign oChecksum = '0;
`endif

endmodule

// File: tb/tb_stream_capture_replay.sv
// Directed + randomized bench for stream_capture_replay (burst and LFSR-gated builds).
module tb_stream_capture_replay;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // burst build
  logic       rst, v_am, rdy_am, v_bm, rdy_bm, done;
  logic [7:0] d_am, d_bm, chk;
  logic [3:0] cnt;
  // LFSR-gated build
  logic       rst2, v2, rdy_am2, v_bm2, rdy2, done2;
  logic [7:0] d2, d_bm2, chk2;
  logic [3:0] cnt2;

  int total = 0;
  int bad   = 0;

  stream_capture_replay #(.SIZE(10), .WIDTH(8), .BURST("yes"), .SEED(16'hACE1)) dut (
    .iCLK(clk), .iRST(rst), .iValid_AM(v_am), .oReady_AM(rdy_am), .iData_AM(d_am),
    .oValid_BM(v_bm), .iReady_BM(rdy_bm), .oData_BM(d_bm), .oCount(cnt),
    .oDone(done), .oChecksum(chk)
  );

  stream_capture_replay #(.SIZE(10), .WIDTH(8), .BURST("no"), .SEED(16'hACE1)) dutn (
    .iCLK(clk), .iRST(rst2), .iValid_AM(v2), .oReady_AM(rdy_am2), .iData_AM(d2),
    .oValid_BM(v_bm2), .iReady_BM(rdy2), .oData_BM(d_bm2), .oCount(cnt2),
    .oDone(done2), .oChecksum(chk2)
  );

`ifdef STREAM_CAPTURE_REPLAY_CHECKSUM_EN
  localparam logic [7:0] CKS_3   = 8'h20;
  localparam logic [7:0] CKS_0_9 = 8'h2D;
`else
  localparam logic [7:0] CKS_3   = 8'h00;
  localparam logic [7:0] CKS_0_9 = 8'h00;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference LFSR: x^16+x^14+x^13+x^11+1, shifting right, output bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 32'(rdy_am), 32'd0);
    check({tag, "_valid"}, 32'(v_bm),   32'd0);
    check({tag, "_data"},  32'(d_bm),   32'd0);
    check({tag, "_count"}, 32'(cnt),    32'd0);
    check({tag, "_done"},  32'(done),   32'd0);
    check({tag, "_cks"},   32'(chk),    32'd0);
  endtask

  // Feed base..base+n-1 back to back; afterwards keep pushing 0xFF.
  task automatic capture(input logic [7:0] base, input int n, output int span, output int nacc);
    int cyc, first, last;
    logic a;
    cyc = 0; first = -1; last = -1; nacc = 0;
    v_am = 1'b1; d_am = base;
    while (nacc < n && cyc < 200) begin
      a = rdy_am;
      tick(); cyc++;
      if (a) begin
        if (first < 0) first = cyc;
        last = cyc;
        nacc++;
        d_am = (nacc < n) ? base + 8'(nacc) : 8'hFF;
      end
    end
    span = last - first + 1;
  endtask

  // Collect up to maxb replay beats, stalling 3 cycles on the first beat equal to stallv.
  task automatic replay(input logic [7:0] base, input int stallv, input int maxb,
                        output int nb, output int cyc);
    logic       h, stalled;
    logic [7:0] dd, e;
    nb = 0; cyc = 0; stalled = 1'b0; rdy_bm = 1'b1;
    while (!done && nb < maxb && cyc < 200) begin
      if (stallv >= 0 && v_bm && d_bm == 8'(stallv) && !stalled) begin
        rdy_bm = 1'b0;
        repeat (3) begin
          tick();
          check("stall_valid", 32'(v_bm), 32'd1);
          check("stall_data",  32'(d_bm), 32'(stallv));
        end
        stalled = 1'b1;
        rdy_bm  = 1'b1;
      end
      h = v_bm && rdy_bm; dd = d_bm;
      check("ovf_ready", 32'(rdy_am), 32'd0);
      tick(); cyc++;
      if (h) begin
        e = base + 8'(nb);
        check("replay_data", 32'(dd), 32'(e));
        nb++;
      end
    end
  endtask

  initial begin
    int span, nacc, nb, cyc;
    logic a;
    logic [7:0] cb [3];
    logic [15:0] lf;
    logic [7:0]  inq[$], outq[$];
    logic acc, hs, exp_r, acc_prev, pv, phs;
    logic [7:0] pd;
    int ncap;

    rst = 1'b1; v_am = 1'b0; d_am = '0; rdy_bm = 1'b0;
    rst2 = 1'b1; v2 = 1'b0; d2 = '0; rdy2 = 1'b0;
    tick(); tick();
    check_idle("reset");
    check("reset2_ready", 32'(rdy_am2), 32'd0);
    check("reset2_valid", 32'(v_bm2),   32'd0);

    // burst capture 0x00..0x09 with replay backpressure on 0x04
    rst = 1'b0; rdy_bm = 1'b1;
    capture(8'h00, 10, span, nacc);
    check("cap_beats", 32'(nacc), 32'd10);
    check("cap_span",  32'(span), 32'd10);
    check("cap_count_cleared", 32'(cnt), 32'd0);
    check("lat_valid_c1", 32'(v_bm), 32'd0);
    tick();
    check("lat_valid_c2", 32'(v_bm), 32'd1);
    check("lat_data_c2",  32'(d_bm), 32'd0);
    replay(8'h00, 4, 10, nb, cyc);
    check("replay_beats",  32'(nb),  32'd10);
    check("replay_cycles", 32'(cyc), 32'd10);
    check("done_flag",  32'(done), 32'd1);
    check("done_count", 32'(cnt),  32'd10);
    check("done_valid", 32'(v_bm), 32'd0);
    check("done_ready", 32'(rdy_am), 32'd0);
    check("done_cks",   32'(chk),  32'(CKS_0_9));
    repeat (3) tick();
    check("done_sticky", 32'(done), 32'd1);
    check("done_valid_hold", 32'(v_bm), 32'd0);

    // checksum wrap: 0x80 + 0x90 + 0x10
    rst = 1'b1; v_am = 1'b0; tick(); rst = 1'b0;
    check("rst_cks", 32'(chk), 32'd0);
    cb[0] = 8'h80; cb[1] = 8'h90; cb[2] = 8'h10;
    v_am = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d_am = cb[i]; a = 1'b0;
      for (int w = 0; w < 20 && !a; w++) begin
        a = rdy_am;
        tick();
      end
      check("cks_accept", 32'(a), 32'd1);
    end
    v_am = 1'b0;
    check("cks_value", 32'(chk), 32'(CKS_3));
    check("cks_count", 32'(cnt), 32'd3);

    // mid-replay reset, then a fresh 0x20..0x29 sequence
    rst = 1'b1; tick(); rst = 1'b0;
    capture(8'h20, 10, span, nacc);
    check("mid_cap_beats", 32'(nacc), 32'd10);
    replay(8'h20, -1, 5, nb, cyc);
    check("mid_partial", 32'(nb), 32'd5);
    check("mid_partial_count", 32'(cnt), 32'd5);
    rst = 1'b1; v_am = 1'b0; tick();
    check_idle("mid_reset");
    rst = 1'b0;
    capture(8'h20, 10, span, nacc);
    check("mid2_cap_beats", 32'(nacc), 32'd10);
    tick();
    replay(8'h20, -1, 10, nb, cyc);
    check("mid2_beats", 32'(nb), 32'd10);
    check("mid2_done",  32'(done), 32'd1);
    v_am = 1'b0;

    // LFSR-gated build with random valid/ready
    rst2 = 1'b0; lf = 16'hACE1;
    ncap = 0; acc_prev = 1'b0; pv = 1'b0; phs = 1'b0; pd = '0;
    cyc = 0;
    while (!done2 && cyc < 3000) begin
      if (!v2 || acc_prev) begin
        v2 = 1'($urandom_range(0, 1));
        d2 = 8'($urandom);
      end
      rdy2  = 1'($urandom_range(0, 1));
      acc   = v2 && rdy_am2;
      hs    = v_bm2 && rdy2;
      exp_r = (ncap < 10) && lf[0] && (ncap < 9 || !acc);
      if (acc) begin inq.push_back(d2); ncap++; end
      if (hs)  outq.push_back(d_bm2);
      pv = v_bm2; pd = d_bm2; phs = hs; acc_prev = acc;
      tick(); cyc++;
      lf = lfsr_next(lf);
      check("rnd_ready", 32'(rdy_am2), 32'(exp_r));
      if (pv && !phs) begin
        check("rnd_hold_valid", 32'(v_bm2), 32'd1);
        check("rnd_hold_data",  32'(d_bm2), 32'(pd));
      end
    end
    check("rnd_done", 32'(done2), 32'd1);
    check("rnd_in_len",  32'(inq.size()),  32'd10);
    check("rnd_out_len", 32'(outq.size()), 32'd10);
    for (int i = 0; i < 10 && i < inq.size() && i < outq.size(); i++)
      check("rnd_seq", 32'(outq[i]), 32'(inq[i]));
    check("rnd_count", 32'(cnt2), 32'd10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
